// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared pipeline-control types.
package cpu_types_pkg;
    localparam int REG_W = 5;
    typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} pctrl_state_t;
    typedef logic [REG_W-1:0] regbits_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: flags a load in ID/EX whose destination feeds the instruction in IF/ID.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             idex_dREN,
    input  logic [REG_W-1:0] idex_wsel,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    output logic             luse
);
    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign luse = idex_dREN & (|idex_wsel) & ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipe registers and PC.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_redirect,
    input  logic             mem_halt,
    input  logic             idex_dREN,
    input  logic [REG_W-1:0] idex_wsel,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    pctrl_state_t state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic luse, mstall, redirect_go;
    logic [8:0] ctl;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .idex_dREN(idex_dREN),
        .idex_wsel(idex_wsel),
        .ifid_rs(ifid_rs),
        .ifid_rt(ifid_rt),
        .luse(luse)
    );

    assign mstall = (mem_dREN | mem_dWEN) & ~dhit & (state_q == RUN || state_q == MEMWAIT);

    // ctl = {pc_en, ifid_en/flush, idex_en/flush, exmem_en/flush, memwb_en/flush}
    always_comb begin
        ctl = 9'b1_10_10_10_10;
        state_d = state_q;
        redirect_go = 1'b0;
        if (state_q == HALTED) ctl = 9'b0;
        else if (state_q == DRAIN) begin
            ctl = 9'b0_00_00_00_10;
            state_d = HALTED;
        end else if (mstall) begin
            ctl = 9'b0_00_00_00_01;
            state_d = MEMWAIT;
        end else if (mem_halt) begin
            ctl = 9'b0_01_01_01_10;
            state_d = DRAIN;
        end else begin
            state_d = RUN;
            if (mem_redirect) begin
                ctl = 9'b1_01_01_01_10;
                redirect_go = 1'b1;
            end else if (luse) ctl = 9'b0_00_01_10_10;
            else if (!ihit) ctl = 9'b0_01_10_10_10;
        end
    end

    assign stall_cnt_d = (!ctl[8] && state_q != HALTED && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    assign flush_cnt_d = (redirect_go && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush} =
        nRST ? ctl : 9'b0_01_01_01_01;
    assign halted = nRST && state_q == HALTED;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule
